// File: rtl/sync_fifo_pkg.sv
// rtl/sync_fifo_pkg.sv - shared types and width helper for the programmable sync FIFO
package sync_fifo_pkg;

  typedef enum logic [1:0] {
    FIFO_IDLE_OP  = 2'b00,
    FIFO_WR_OP    = 2'b01,
    FIFO_RD_OP    = 2'b10,
    FIFO_WR_RD_OP = 2'b11
  } fifo_op_e;

  function automatic int fifo_cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// rtl/sync_fifo_ram.sv - FIFO storage, one sync write port and one sync read port, no reset
module sync_fifo_ram #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem_q[rd_addr];
  end

endmodule

// File: rtl/sync_fifo_prog.sv
// rtl/sync_fifo_prog.sv - single-clock FIFO with programmable thresholds and flush
// Optional SYNC_FIFO_WATERMARK_EN adds the peak_count occupancy watermark output.
module sync_fifo_prog
  import sync_fifo_pkg::*;
#(
  parameter int FIFO_WIDTH = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int AF_THRESH  = FIFO_DEPTH - 1,
  parameter int AE_THRESH  = 1,
  localparam int PTR_W     = $clog2(FIFO_DEPTH),
  localparam int CNT_W     = fifo_cnt_w(FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [FIFO_WIDTH-1:0] data_in,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic                  flush,
  output logic [FIFO_WIDTH-1:0] data_out,
  output logic                  wr_ack,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  full,
  output logic                  almostfull,
  output logic                  empty,
  output logic                  almostempty,
  output logic [CNT_W-1:0]      count
`ifdef SYNC_FIFO_WATERMARK_EN
  ,
  output logic [CNT_W-1:0]      peak_count
`endif
);

  if (FIFO_DEPTH < 2 || AF_THRESH < 1 || AF_THRESH > FIFO_DEPTH - 1 ||
      AE_THRESH < 1 || AE_THRESH > FIFO_DEPTH - 1) begin : g_param_err
    $error("sync_fifo_prog: illegal FIFO_DEPTH or threshold parameter");
  end

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             wr_ack_q, wr_ack_d, overflow_q, overflow_d, underflow_q, underflow_d;
  logic             loaded_q, loaded_d;
  logic             wr_acc, rd_acc, ram_wr, ram_rd;
  logic [FIFO_WIDTH-1:0] ram_rdata;
  fifo_op_e         op;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full        = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty       = (count_q == '0);
  assign almostfull  = (count_q >= CNT_W'(AF_THRESH)) & ~full;
  assign almostempty = (count_q <= CNT_W'(AE_THRESH)) & ~empty;

  assign wr_acc = wr_en & ~full;
  assign rd_acc = rd_en & ~empty;
  assign op     = fifo_op_e'({rd_acc, wr_acc});
  assign ram_wr = wr_acc & ~flush;
  assign ram_rd = rd_acc & ~flush;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    loaded_d    = loaded_q;
    wr_ack_d    = 1'b0;
    overflow_d  = 1'b0;
    underflow_d = 1'b0;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      wr_ack_d    = wr_acc;
      overflow_d  = wr_en & full;
      underflow_d = rd_en & empty;
      unique case (op)
        FIFO_WR_OP: begin
          wr_ptr_d = ptr_inc(wr_ptr_q);
          count_d  = count_q + CNT_W'(1);
        end
        FIFO_RD_OP: begin
          rd_ptr_d = ptr_inc(rd_ptr_q);
          count_d  = count_q - CNT_W'(1);
          loaded_d = 1'b1;
        end
        FIFO_WR_RD_OP: begin
          wr_ptr_d = ptr_inc(wr_ptr_q);
          rd_ptr_d = ptr_inc(rd_ptr_q);
          loaded_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      loaded_q    <= 1'b0;
      wr_ack_q    <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      loaded_q    <= loaded_d;
      wr_ack_q    <= wr_ack_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  sync_fifo_ram #(
    .WIDTH (FIFO_WIDTH),
    .DEPTH (FIFO_DEPTH),
    .AW    (PTR_W)
  ) u_ram (
    .clk     (clk),
    .wr_en   (ram_wr),
    .wr_addr (wr_ptr_q),
    .wr_data (data_in),
    .rd_en   (ram_rd),
    .rd_addr (rd_ptr_q),
    .rd_data (ram_rdata)
  );

  // The RAM has no reset, so data_out reads as 0 until the first accepted read.
  assign data_out  = loaded_q ? ram_rdata : '0;
  assign wr_ack    = wr_ack_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;
  assign count     = count_q;

`ifdef SYNC_FIFO_WATERMARK_EN
  logic [CNT_W-1:0] peak_q, peak_d;

  always_comb begin
    peak_d = peak_q;
    if (flush)                peak_d = '0;
    else if (count_q > peak_q) peak_d = count_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) peak_q <= '0;
    else        peak_q <= peak_d;
  end

  assign peak_count = peak_q;
`endif

endmodule

// File: tb/tb_sync_fifo_prog.sv
// tb/tb_sync_fifo_prog.sv - randomized bench for sync_fifo_prog against a queue model
module tb_sync_fifo_prog;
  import sync_fifo_pkg::*;

  localparam int W     = 16;
  localparam int DEPTH = 6;
  localparam int AF    = 4;
  localparam int AE    = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [W-1:0]  data_in = '0;
  logic          wr_en = 1'b0, rd_en = 1'b0, flush = 1'b0;
  logic [W-1:0]  data_out;
  logic          wr_ack, overflow, underflow, full, almostfull, empty, almostempty;
  logic [2:0]    count;
`ifdef SYNC_FIFO_WATERMARK_EN
  logic [2:0]    peak_count;
`endif

  sync_fifo_prog #(
    .FIFO_WIDTH (W),
    .FIFO_DEPTH (DEPTH),
    .AF_THRESH  (AF),
    .AE_THRESH  (AE)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .data_in     (data_in),
    .wr_en       (wr_en),
    .rd_en       (rd_en),
    .flush       (flush),
    .data_out    (data_out),
    .wr_ack      (wr_ack),
    .overflow    (overflow),
    .underflow   (underflow),
    .full        (full),
    .almostfull  (almostfull),
    .empty       (empty),
    .almostempty (almostempty),
    .count       (count)
`ifdef SYNC_FIFO_WATERMARK_EN
    ,
    .peak_count  (peak_count)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [W-1:0] q[$];
  logic [W-1:0] m_dout;
  bit           m_ack, m_ovf, m_unf;
  int           m_peak, m_wr_tot, m_rd_tot;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_dout = '0;
    m_ack = 0; m_ovf = 0; m_unf = 0;
    m_peak = 0; m_wr_tot = 0; m_rd_tot = 0;
  endtask

  task automatic model_update(input bit w, input bit r, input bit f, input logic [W-1:0] d);
    int n;
    bit wa, ra;
    fifo_op_e op;
    n = q.size();
    if (f) begin
      q.delete();
      m_ack = 0; m_ovf = 0; m_unf = 0;
      m_peak = 0; m_wr_tot = 0; m_rd_tot = 0;
      return;
    end
    if (n > m_peak) m_peak = n;
    wa = w && (n < DEPTH);
    ra = r && (n > 0);
    m_ack = wa;
    m_ovf = w && (n == DEPTH);
    m_unf = r && (n == 0);
    op = fifo_op_e'({ra, wa});
    case (op)
      FIFO_WR_OP:    begin q.push_back(d); m_wr_tot++; end
      FIFO_RD_OP:    begin m_dout = q.pop_front(); m_rd_tot++; end
      FIFO_WR_RD_OP: begin m_dout = q.pop_front(); q.push_back(d); m_wr_tot++; m_rd_tot++; end
      default: ;
    endcase
  endtask

  task automatic check_all(input string tag);
    int n;
    n = q.size();
    check({tag, ".count"},     32'(count),       32'(n));
    check({tag, ".full"},      32'(full),        32'(n == DEPTH));
    check({tag, ".empty"},     32'(empty),       32'(n == 0));
    check({tag, ".afull"},     32'(almostfull),  32'(n >= AF && n != DEPTH));
    check({tag, ".aempty"},    32'(almostempty), 32'(n <= AE && n != 0));
    check({tag, ".wr_ack"},    32'(wr_ack),      32'(m_ack));
    check({tag, ".overflow"},  32'(overflow),    32'(m_ovf));
    check({tag, ".underflow"}, 32'(underflow),   32'(m_unf));
    check({tag, ".data_out"},  32'(data_out),    32'(m_dout));
    check({tag, ".wr_ptr"},    32'(dut.wr_ptr_q), 32'(m_wr_tot % DEPTH));
    check({tag, ".rd_ptr"},    32'(dut.rd_ptr_q), 32'(m_rd_tot % DEPTH));
`ifdef SYNC_FIFO_WATERMARK_EN
    check({tag, ".peak"},      32'(peak_count),  32'(m_peak));
`endif
  endtask

  task automatic step(input bit w, input bit r, input bit f, input logic [W-1:0] d, input string tag);
    @(negedge clk);
    wr_en = w; rd_en = r; flush = f; data_in = d;
    @(posedge clk);
    model_update(w, r, f, d);
    #1 check_all(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    wr_en = 0; rd_en = 0; flush = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all("reset");
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    do_reset();

    for (int i = 1; i <= 7; i++) step(1, 0, 0, W'(i), "fill");
    for (int i = 0; i < 7; i++) step(0, 1, 0, '0, "drain");
    check("drain.hold", 32'(data_out), 32'h6);

    for (int i = 0; i < 50; i++) step(((i / 4) % 2) == 0, ((i / 4) % 2) == 1, 0, W'($urandom), "wrap");
    while (q.size() > 0) step(0, 1, 0, '0, "wrap_drain");

    for (int i = 0; i < DEPTH; i++) step(1, 0, 0, W'($urandom), "sim_fill");
    step(1, 1, 0, W'($urandom), "sim_full");
    while (q.size() > 0) step(0, 1, 0, '0, "sim_drain");
    step(1, 1, 0, W'($urandom), "sim_empty");
    step(1, 0, 0, W'($urandom), "sim_to3");
    step(1, 0, 0, W'($urandom), "sim_to3");
    step(1, 1, 0, W'($urandom), "sim_mid");
    check("sim_mid.count3", 32'(count), 32'd3);

    step(1, 0, 0, W'($urandom), "fl_to4");
    step(1, 0, 1, W'($urandom), "flush");
    check("flush.empty", 32'(empty), 32'd1);
    step(1, 0, 0, 16'hBEEF, "beef_wr");
    step(0, 1, 0, '0, "beef_rd");
    check("beef.data", 32'(data_out), 32'hBEEF);

    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 31) == 0,
           W'($urandom), "rand");

    step(0, 0, 1, '0, "pre_async");
    for (int i = 0; i < 3; i++) step(1, 0, 0, W'($urandom), "async_fill");
    @(negedge clk);
    wr_en = 1'b1; data_in = 16'h1234;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("async.count", 32'(count), 32'd0);
    check("async.empty", 32'(empty), 32'd1);
    check_all("async");
    @(negedge clk);
    wr_en = 1'b0;
    rst_n = 1'b1;
    step(1, 0, 0, 16'h00A5, "post_rst_wr");
    step(0, 1, 0, '0, "post_rst_rd");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
